mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter that shares the single-port instruction RAM (synchronous write, asynchronous `spo` read) between the CPU instruction-fetch port and the CPU data port. It sits between `mycpu_top` and `inst_ram` in the board top, so loads and stores reach real memory instead of only `confreg`. A bounded-starvation rule keeps fetch alive during long data sequences.

## Interface
Parameters:
- `ADDR_W`, 16: RAM word-address width.
- `DATA_W`, 32: data width.
- `MAX_D_RUN`, 4: maximum consecutive data grants while `i_req` is pending.

Ports:
- `clk_50M`  in  1  clock; one clock, all state on its rising edge
- `reset_btn`  in  1  synchronous, active-high reset
- `i_req`  in  1  fetch request (read only)
- `i_addr`  in  32  fetch byte address
- `i_ack`  out  1  one-cycle fetch completion pulse
- `i_rdata`  out  DATA_W  fetch data, valid while `i_ack`=1
- `d_req`  in  1  data request
- `d_wen`  in  1  1 = write, 0 = read
- `d_addr`  in  32  data byte address
- `d_wdata`  in  DATA_W  write data
- `d_ack`  out  1  one-cycle data completion pulse
- `d_rdata`  out  DATA_W  read data, valid while `d_ack`=1 for reads
- `ram_we`  out  1  RAM write enable
- `ram_a`  out  ADDR_W  RAM word address
- `ram_d`  out  DATA_W  RAM write data
- `ram_spo`  in  DATA_W  RAM asynchronous read data

## Operation
- States: `IDLE`, `GNT_I`, `GNT_D`, `RSP_I`, `RSP_D`.
- Arbitration happens in `IDLE`, `RSP_I` and `RSP_D`. Next state:
  - `GNT_D` if `d_req` and (`i_req`=0 or `run` < `MAX_D_RUN`).
  - Otherwise `GNT_I` if `i_req`.
  - Otherwise `IDLE`.
- `GNT_x` always goes to `RSP_x`.
- `run` is a saturating counter:
  - It increments on a `GNT_D` decision taken while `i_req`=1.
  - It clears on a `GNT_I` decision, and on any arbitration with `i_req`=0.
- `GNT_I` drives RAM from the fetch port: `ram_a`=`i_addr[ADDR_W+1:2]`, `ram_we`=0.
- `GNT_D` drives RAM from the data port: `ram_a`=`d_addr[ADDR_W+1:2]`, `ram_d`=`d_wdata`, `ram_we`=`d_wen`.
- When neither grant state is active, `ram_we`=0 and `ram_a`/`ram_d`=0.
- Address bits above `ADDR_W+1` are ignored, so addresses alias. Low two bits are ignored.
- `ram_spo` is captured into `i_rdata` at the end of `GNT_I`, and into `d_rdata` at the end of a read `GNT_D`. A write grant leaves `d_rdata` unchanged.
- `i_ack`=1 only in `RSP_I`; `d_ack`=1 only in `RSP_D`. Both are registered.
- Requester rule: hold `*_addr`, `d_wen` and `d_wdata` stable from `req` assertion through the ack cycle.
- A `req` still high during its own ack cycle counts as a new request; its fields are read in the following grant cycle.

## Timing
- Reset (sync, `reset_btn`=1 at an edge) sets:
  - state=`IDLE`, `run`=0;
  - `i_ack`=`d_ack`=0;
  - `i_rdata`=`d_rdata`=0.
- `ram_we` is forced 0 in any cycle where `reset_btn`=1. A write granted in that cycle is dropped, and no ack follows.
- Latency: `req` first high in cycle 0 from `IDLE` → grant in cycle 1 → ack in cycle 2. A write commits at the end of cycle 1.
- Throughput is one access per 2 cycles for back-to-back requests; the `RSP_x` → `GNT_y` chaining has no idle bubble.
- Simultaneous `i_req` and `d_req` in `IDLE`: data wins while `run` < `MAX_D_RUN`.
- With both requests continuously high, the pattern is `MAX_D_RUN` data grants, 1 fetch grant, repeating.
- Dropping `req` before ack is illegal; behaviour is undefined except that at most one RAM write occurs.
- Reset in a grant or response state aborts immediately; no ack is issued afterwards.

## Structure
- Package `mem_arb_pkg`: state encoding constants (`IDLE`, `GNT_I`, `GNT_D`, `RSP_I`, `RSP_D`) and default `ADDR_W`/`DATA_W`.
- Single module. No sub-module is required; `run` stays inline as a small saturating counter of width `$clog2(MAX_D_RUN+1)`.

## Test plan
- Reset: hold `reset_btn` 2 cycles → all outputs 0, state `IDLE`; with no requests, `ram_we` stays 0 for 10 cycles.
- Fetch: RAM[0x10]=0x1234_5678, `i_req`=1, `i_addr`=0x40 in cycle 0 → `ram_a`=0x10 in cycle 1; `i_ack`=1 and `i_rdata`=0x1234_5678 in cycle 2.
- Write then read: `d_wen`=1, `d_addr`=0x80, `d_wdata`=0xDEAD_BEEF → `ram_we`=1 one cycle, `d_ack` in cycle 2. Then a read at 0x80 returns 0xDEAD_BEEF, with `d_rdata` unchanged across the write ack.
- Contention: both requests held high 20 cycles, `MAX_D_RUN`=4 → grant order D,D,D,D,I repeated. No two acks are ever high in the same cycle; one ack every 2 cycles.
- Alias: `d_addr`=0x0004_0040 (`ADDR_W`=16) → `ram_a`=0x0010.
- Reset mid-write: assert `reset_btn` during `GNT_D` with `d_wen`=1 → `ram_we`=0 that cycle, RAM unchanged, no `d_ack`.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the fetch/data RAM port arbiter.
// Holds the state encoding and the default RAM geometry.
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned BYTE_ADDR_W = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GNT_I = 3'd1,
    GNT_D = 3'd2,
    RSP_I = 3'd3,
    RSP_D = 3'd4
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM (sync write, async read) between instruction
// fetch and data access, with a bounded run of data grants while fetch waits.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned MAX_D_RUN = 4
) (
  input  logic                   clk_50M,
  input  logic                   reset_btn,
  input  logic                   i_req,
  input  logic [BYTE_ADDR_W-1:0] i_addr,
  output logic                   i_ack,
  output logic [DATA_W-1:0]      i_rdata,
  input  logic                   d_req,
  input  logic                   d_wen,
  input  logic [BYTE_ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0]      d_wdata,
  output logic                   d_ack,
  output logic [DATA_W-1:0]      d_rdata,
  output logic                   ram_we,
  output logic [ADDR_W-1:0]      ram_a,
  output logic [DATA_W-1:0]      ram_d,
  input  logic [DATA_W-1:0]      ram_spo
);

  localparam int unsigned RUN_W = $clog2(MAX_D_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_D_RUN);
  localparam logic [RUN_W-1:0] RUN_SAT   = '1;

  arb_state_t       state;
  logic [RUN_W-1:0] run;
  logic             arb_slot;
  logic             pick_d;
  logic             pick_i;
  logic             unused_addr_bits;

  // Arbitration is only live in IDLE and the response states; data wins
  // unless fetch is waiting and data has already used up its run.
  always_comb begin
    arb_slot = (state == IDLE) || (state == RSP_I) || (state == RSP_D);
    pick_d   = arb_slot && d_req && (!i_req || (run < RUN_LIMIT));
    pick_i   = arb_slot && i_req && !pick_d;
  end

  always_ff @(posedge clk_50M) begin
    if (reset_btn) begin
      state   <= IDLE;
      run     <= '0;
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;

      unique case (state)
        GNT_I: begin
          state   <= RSP_I;
          i_ack   <= 1'b1;
          i_rdata <= ram_spo;
        end
        GNT_D: begin
          state <= RSP_D;
          d_ack <= 1'b1;
          if (!d_wen) begin
            d_rdata <= ram_spo;
          end
        end
        default: begin
          if (pick_d) begin
            state <= GNT_D;
          end else if (pick_i) begin
            state <= GNT_I;
          end else begin
            state <= IDLE;
          end
        end
      endcase

      // Run length of data grants taken while fetch is pending.
      if (arb_slot) begin
        if (!i_req) begin
          run <= '0;
        end else if (pick_d) begin
          if (run != RUN_SAT) begin
            run <= run + RUN_W'(1);
          end
        end else begin
          run <= '0;
        end
      end
    end
  end

  // RAM port follows the grant state directly so the async read settles
  // within the grant cycle; a write is suppressed whenever reset is high.
  always_comb begin
    ram_we = 1'b0;
    ram_a  = '0;
    ram_d  = '0;
    if (state == GNT_I) begin
      ram_a = i_addr[ADDR_W+1:2];
    end else if (state == GNT_D) begin
      ram_a  = d_addr[ADDR_W+1:2];
      ram_d  = d_wdata;
      ram_we = d_wen && !reset_btn;
    end
  end

  // Byte-offset and aliased upper address bits are intentionally dropped.
  assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0],
                              i_addr[BYTE_ADDR_W-1:ADDR_W+2],
                              d_addr[BYTE_ADDR_W-1:ADDR_W+2]};

  a_single_ack : assert property (@(posedge clk_50M) disable iff (reset_btn)
    !(i_ack && d_ack));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter with a RAM model and a
// transaction-level reference of memory contents and grant fairness.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned MAX_D_RUN = 4;
  localparam int unsigned N_RAND    = 3000;
  localparam int unsigned WAIT_MAX  = 24;
  localparam logic [31:0] D_VAL     = 32'hD0D0_0100;
  localparam logic [31:0] I_VAL     = 32'h1F1F_0200;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_req;
  logic [31:0]       i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req;
  logic              d_wen;
  logic [31:0]       d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_a;
  logic [DATA_W-1:0] ram_d;
  logic [DATA_W-1:0] ram_spo;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic              bd_we = 1'b0;
  logic [ADDR_W-1:0] bd_a;
  logic [DATA_W-1:0] bd_d;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_D_RUN(MAX_D_RUN)) dut (
    .clk_50M(clk), .reset_btn(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .ram_we(ram_we), .ram_a(ram_a), .ram_d(ram_d), .ram_spo(ram_spo)
  );

  always #5 clk = ~clk;

  // Single-port RAM: async read, sync write, plus a preload port for the bench.
  assign ram_spo = mem[ram_a];
  always @(posedge clk) begin
    if (ram_we) mem[ram_a] <= ram_d;
    if (bd_we) mem[bd_a] <= bd_d;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bd_a  = a;
    bd_d  = d;
    bd_we = 1'b1;
    step();
    bd_we = 1'b0;
  endtask

  function automatic logic [31:0] mk_addr(input int w);
    logic [31:0] a;
    a = $urandom;
    a[ADDR_W+1:2] = ADDR_W'(w);
    return a;
  endfunction

  logic [31:0] ref_mem [16];
  bit          hi [4];
  bit          hd [4];

  initial begin
    int   cyc, cnt, iw, dw, iwait, dwait, g;
    bit   ib, db, dwr, pi, pd, exp_d, exp_i, done;
    logic [31:0] dwd, d_last;

    rst = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_wen = 1'b0; d_addr = '0; d_wdata = '0;

    // Preload under reset; the arbiter cannot write while reset is high.
    preload(16'h0010, 32'h1234_5678);
    preload(16'h0020, 32'h0000_0000);
    preload(16'h0030, 32'h0BAD_F00D);
    preload(16'h0100, D_VAL);
    preload(16'h0200, I_VAL);
    for (int w = 0; w < 16; w++) begin
      ref_mem[w] = $urandom;
      preload(ADDR_W'(w), ref_mem[w]);
    end

    step();
    step();
    chk("rst_i_ack", i_ack, 0);
    chk("rst_d_ack", d_ack, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_a", ram_a, 0);
    chk("rst_ram_d", ram_d, 0);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("idle_ram_we", ram_we, 0);
    end

    // Single fetch.
    i_req = 1'b1; i_addr = 32'h0000_0040;
    step();
    chk("fetch_ram_a", ram_a, 16'h0010);
    chk("fetch_ram_we", ram_we, 0);
    chk("fetch_early_ack", i_ack, 0);
    step();
    chk("fetch_ack", i_ack, 1);
    chk("fetch_rdata", i_rdata, 32'h1234_5678);
    i_req = 1'b0;
    step();
    chk("fetch_ack_pulse", i_ack, 0);

    // Write then read back.
    d_req = 1'b1; d_wen = 1'b1; d_addr = 32'h0000_0080; d_wdata = 32'hDEAD_BEEF;
    step();
    chk("wr_ram_we", ram_we, 1);
    chk("wr_ram_a", ram_a, 16'h0020);
    chk("wr_ram_d", ram_d, 32'hDEAD_BEEF);
    step();
    chk("wr_ack", d_ack, 1);
    chk("wr_d_rdata_hold", d_rdata, 0);
    chk("wr_ram_we_once", ram_we, 0);
    chk("wr_mem", mem[16'h0020], 32'hDEAD_BEEF);
    d_req = 1'b0;
    step();
    d_req = 1'b1; d_wen = 1'b0;
    step();
    chk("rd_ram_we", ram_we, 0);
    step();
    chk("rd_ack", d_ack, 1);
    chk("rd_data", d_rdata, 32'hDEAD_BEEF);
    d_req = 1'b0;
    step();

    // Upper address bits alias.
    d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h0004_0040;
    step();
    chk("alias_ram_a", ram_a, 16'h0010);
    step();
    chk("alias_data", d_rdata, 32'h1234_5678);
    d_req = 1'b0;
    step();

    // Reset during a write grant.
    d_req = 1'b1; d_wen = 1'b1; d_addr = 32'h0000_00C0; d_wdata = 32'hA5A5_A5A5;
    step();
    chk("rstwr_pre_we", ram_we, 1);
    rst = 1'b1; d_req = 1'b0;
    #1;
    chk("rstwr_we_forced", ram_we, 0);
    step();
    rst = 1'b0;
    chk("rstwr_mem", mem[16'h0030], 32'h0BAD_F00D);
    chk("rstwr_no_ack", d_ack, 0);
    chk("rstwr_d_rdata", d_rdata, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rstwr_no_late_ack", d_ack, 0);
    end

    // Both requesters held: MAX_D_RUN data grants, then one fetch.
    d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h0000_0400;
    i_req = 1'b1; i_addr = 32'h0000_0800;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k % 2 == 1) begin
        chk("cont_gap_i", i_ack, 0);
        chk("cont_gap_d", d_ack, 0);
      end else begin
        g = k / 2 - 1;
        exp_i = ((g % (MAX_D_RUN + 1)) == MAX_D_RUN);
        chk("cont_i_ack", i_ack, exp_i);
        chk("cont_d_ack", d_ack, !exp_i);
        if (exp_i) chk("cont_i_data", i_rdata, I_VAL);
        else       chk("cont_d_data", d_rdata, D_VAL);
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    step();
    step();

    // Random traffic against the reference memory and grant rule.
    d_last = D_VAL;
    cyc = 0; cnt = 0; ib = 0; db = 0; iw = 0; dw = 0; dwr = 0; dwd = '0;
    iwait = 0; dwait = 0; done = 0;
    for (int k = 0; k < 4; k++) begin
      hi[k] = 0;
      hd[k] = 0;
    end
    while (!done) begin
      step();
      cyc++;
      chk("dual_ack", i_ack & d_ack, 0);
      if (i_ack || d_ack) begin
        pi = hi[(cyc + 2) % 4];
        pd = hd[(cyc + 2) % 4];
        exp_d = pd && (!pi || cnt < int'(MAX_D_RUN));
        chk("arb_pick_d", d_ack, exp_d);
        if (!pi) cnt = 0;
        else if (exp_d) cnt++;
        else cnt = 0;
      end
      if (i_ack) begin
        chk("i_ack_spur", ib, 1);
        chk("i_rdata", i_rdata, ref_mem[iw]);
        ib = 0;
      end
      if (d_ack) begin
        chk("d_ack_spur", db, 1);
        if (dwr) begin
          chk("d_rdata_wr_hold", d_rdata, d_last);
          ref_mem[dw] = dwd;
        end else begin
          chk("d_rdata_rd", d_rdata, ref_mem[dw]);
          d_last = ref_mem[dw];
        end
        db = 0;
      end
      if (ib) iwait++;
      if (db) dwait++;
      if (iwait > int'(WAIT_MAX)) begin
        chk("i_timeout", iwait, WAIT_MAX);
        done = 1;
      end
      if (dwait > int'(WAIT_MAX)) begin
        chk("d_timeout", dwait, WAIT_MAX);
        done = 1;
      end
      if (cyc < int'(N_RAND) && !done) begin
        if (!ib && $urandom_range(0, 3) != 0) begin
          ib = 1; iwait = 0;
          iw = $urandom_range(0, 15);
          i_addr = mk_addr(iw);
        end
        if (!db && $urandom_range(0, 4) != 0) begin
          db = 1; dwait = 0;
          dw = $urandom_range(0, 15);
          dwr = $urandom_range(0, 1);
          dwd = $urandom;
          d_addr = mk_addr(dw);
          d_wen = dwr;
          d_wdata = dwd;
        end
      end
      i_req = ib;
      d_req = db;
      hi[cyc % 4] = ib;
      hd[cyc % 4] = db;
      if (cyc >= int'(N_RAND) && !ib && !db) done = 1;
    end
    i_req = 1'b0; d_req = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
